// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register bank.
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam logic [APB_DATA_W-1:0] APB_DEFAULT_ID = 32'hA9B0_0001;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_RANGE     = 2'd1,
    ERR_READ_ONLY = 2'd2
  } apb_err_e;

  // Range violations take precedence over the read-only ID check.
  function automatic apb_err_e apb_err_cause(input logic in_range,
                                             input logic write,
                                             input logic is_id);
    if (!in_range) return ERR_RANGE;
    if (write && is_id) return ERR_READ_ONLY;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between requester and completer.
// The PSTRB lane exists only when APB_SLV_PSTRB_EN is defined.
interface apb_slave_regbank_if #(
  parameter int ADDR_W = 5
);
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
`ifdef APB_SLV_PSTRB_EN
  logic [APB_STRB_W-1:0] PSTRB;
`endif
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLV_PSTRB_EN
    output PSTRB,
`endif
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  PSTRB,
`endif
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_regfile.sv
// Register array with synchronous clear, one registered read port and a
// byte-strobed write port. Index 0 is not writable storage; it reads ID_VALUE.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = APB_DEFAULT_ID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_load,
  input  logic                  rd_hit,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [APB_DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [APB_STRB_W-1:0] wr_strb,
  input  logic [APB_DATA_W-1:0] wr_data
);

  logic [APB_DATA_W-1:0] mem [NUM_REGS];

  logic              rd_ok;
  logic              wr_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;

  // Indices are forced to 0 when out of range so the array is never overrun.
  assign rd_ok  = rd_hit && (32'(rd_addr) < NUM_REGS);
  assign wr_ok  = wr_en && (32'(wr_addr) < NUM_REGS) && (wr_addr != '0);
  assign rd_idx = rd_ok ? rd_addr : '0;
  assign wr_idx = wr_ok ? wr_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_ok) begin
        for (int b = 0; b < APB_STRB_W; b++) begin
          if (wr_strb[b]) begin
            mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      if (rd_load) begin
        if (!rd_ok) begin
          rd_data <= '0;
        end else if (rd_addr == '0) begin
          rd_data <= ID_VALUE;
        end else begin
          rd_data <= mem[rd_idx];
        end
      end
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer: register bank with programmable wait states and error flags.
// Define APB_SLV_PSTRB_EN to enable byte-strobed writes via PSTRB.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter int WAIT_STATES = 0,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA9B0_0001
) (
  input logic                PCLK,
  input logic                PRESET,
  apb_slave_regbank_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  apb_state_e            state;
  logic [3:0]            cnt;
  apb_err_e              err_cause;
  logic [ADDR_W-1:0]     lat_addr;
  logic                  lat_write;
  logic [APB_DATA_W-1:0] lat_wdata;
  logic [APB_STRB_W-1:0] lat_strb;

  logic                  setup;
  logic                  addr_in_range;
  logic                  done;
  logic                  commit;
  apb_err_e              setup_cause;
  logic [APB_STRB_W-1:0] setup_strb;

  assign setup         = (state == IDLE) && bus.PSEL && !bus.PENABLE;
  assign addr_in_range = 32'(bus.PADDR) < NUM_REGS;
  assign setup_cause   = apb_err_cause(addr_in_range, bus.PWRITE, bus.PADDR == '0);
  assign done          = (state == ACCESS) && (cnt == 4'd0);
  assign commit        = done && lat_write && (err_cause == ERR_NONE);

`ifdef APB_SLV_PSTRB_EN
  assign setup_strb = bus.PSTRB;
`else
  assign setup_strb = '1;
`endif

  // Completion flags decode from registered state only.
  assign bus.PREADY  = done;
  assign bus.PSLVERR = done && (err_cause != ERR_NONE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      err_cause <= ERR_NONE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
      lat_strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state     <= ACCESS;
            cnt       <= WAIT_LOAD;
            err_cause <= setup_cause;
            lat_addr  <= bus.PADDR;
            lat_write <= bus.PWRITE;
            lat_wdata <= bus.PWDATA;
            lat_strb  <= setup_strb;
          end
        end
        ACCESS: begin
          if (done) begin
            state <= IDLE;
          end else if (!bus.PSEL || !bus.PENABLE) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_regfile #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk     (PCLK),
    .rst     (PRESET),
    .rd_load (setup),
    .rd_hit  (!bus.PWRITE && addr_in_range),
    .rd_addr (bus.PADDR),
    .rd_data (bus.PRDATA),
    .wr_en   (commit),
    .wr_addr (lat_addr),
    .wr_strb (lat_strb),
    .wr_data (lat_wdata)
  );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank (WAIT_STATES=2, NUM_REGS=24).
// PSTRB scenarios run only when APB_SLV_PSTRB_EN is defined.
module tb_apb_slave_regbank;

  localparam int          AW  = 5;
  localparam int          NR  = 24;
  localparam int          WS  = 2;
  localparam logic [31:0] IDV = 32'hA9B0_0001;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  int   errorCount = 0;
  int   checkCount = 0;
  exp_t expQ[$];
  logic [31:0] model [32];

  apb_slave_regbank_if #(.ADDR_W(AW)) bus ();

  apb_slave_regbank #(
    .ADDR_W      (AW),
    .NUM_REGS    (NR),
    .WAIT_STATES (WS),
    .ID_VALUE    (IDV)
  ) dut (
    .PCLK   (pclk),
    .PRESET (preset),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic driveIdle();
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  // Enter at #1 after a rising edge; leave at #1 after the completion edge.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    exp_t got;
    logic [3:0] eff;
    logic in_range;
    int waits;
    bit done;
`ifdef APB_SLV_PSTRB_EN
    eff = strb;
`else
    eff = 4'hF;
`endif
    in_range  = (32'(addr) < NR);
    e.is_read = !wr;
    e.err     = !in_range || (wr && addr == '0);
    e.rdata   = (!wr && in_range) ? ((addr == '0) ? IDV : model[addr]) : 32'h0;
    if (wr && !e.err) begin
      for (int b = 0; b < 4; b++) begin
        if (eff[b]) model[addr][8*b +: 8] = data[8*b +: 8];
      end
    end
    expQ.push_back(e);

    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = wr;
    bus.PADDR = addr;
    bus.PWDATA = data;
`ifdef APB_SLV_PSTRB_EN
    bus.PSTRB = strb;
`endif
    @(posedge pclk); #1;
    bus.PENABLE = 1'b1;
    waits = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge pclk);
      if (bus.PREADY) begin
        got = expQ.pop_front();
        if (got.is_read) checkOutput($sformatf("prdata@%0d", addr), bus.PRDATA, got.rdata);
        checkOutput($sformatf("pslverr@%0d", addr), 32'(bus.PSLVERR), 32'(got.err));
        checkOutput($sformatf("latency@%0d", addr), waits, WS);
        done = 1;
      end else begin
        waits++;
      end
      @(posedge pclk); #1;
    end
    if (!done) begin
      checkOutput("timeout", 32'd0, 32'd1);
      void'(expQ.pop_front());
    end
    driveIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawReady;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    bus.PSEL = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b0;
    bus.PADDR = '0;
    bus.PWDATA = '0;
`ifdef APB_SLV_PSTRB_EN
    bus.PSTRB = 4'h0;
`endif

    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    checkOutput("reset_pready", 32'(bus.PREADY), 32'd0);
    checkOutput("reset_pslverr", 32'(bus.PSLVERR), 32'd0);
    checkOutput("reset_prdata", bus.PRDATA, 32'h0);
    @(posedge pclk); #1;

    // ID read, write/read-back, then back-to-back traffic with no idle cycle
    applyStimulus(1'b0, 5'd0, 32'h0, 4'hF);
    applyStimulus(1'b1, 5'b10010, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b0, 5'b10010, 32'h0, 4'hF);
    applyStimulus(1'b1, 5'b10101, 32'hDABBCAFE, 4'hF);
    applyStimulus(1'b0, 5'b10010, 32'h0, 4'hF);
    applyStimulus(1'b0, 5'b10101, 32'h0, 4'hF);

    // Error cases and range boundaries
    applyStimulus(1'b1, 5'd0, 32'h1234, 4'hF);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'hF);
    applyStimulus(1'b1, 5'd23, 32'h0BAD_F00D, 4'hF);
    applyStimulus(1'b0, 5'd23, 32'h0, 4'hF);
    applyStimulus(1'b1, 5'd24, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, 5'd25, 32'h0, 4'hF);
    applyStimulus(1'b0, 5'd31, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, AW'(k + 8), $urandom, 4'hF);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, AW'(k + 8), 32'h0, 4'hF);
    end

    // Abort a write during a wait state
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b1;
    bus.PADDR = 5'd3;
    bus.PWDATA = 32'h55;
    @(posedge pclk); #1;
    bus.PENABLE = 1'b1;
    @(posedge pclk); #1;
    driveIdle();
    sawReady = 0;
    repeat (5) begin
      @(negedge pclk);
      if (bus.PREADY) sawReady = 1;
    end
    checkOutput("abort_pready", 32'(sawReady), 32'd0);
    @(posedge pclk); #1;
    applyStimulus(1'b0, 5'd3, 32'h0, 4'hF);

`ifdef APB_SLV_PSTRB_EN
    applyStimulus(1'b1, 5'd4, 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b1, 5'd4, 32'h1111_2222, 4'b0011);
    applyStimulus(1'b0, 5'd4, 32'h0, 4'hF);
    applyStimulus(1'b1, 5'd4, 32'hFFFF_FFFF, 4'b0000);
    applyStimulus(1'b0, 5'd4, 32'h0, 4'hF);
    applyStimulus(1'b1, 5'd4, 32'hAABB_CCDD, 4'b1000);
    applyStimulus(1'b0, 5'd4, 32'h0, 4'hF);
`endif

    // Reset asserted during the completion cycle of a write
    bus.PSEL = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE = 1'b1;
    bus.PADDR = 5'd7;
    bus.PWDATA = 32'h77;
    @(posedge pclk); #1;
    bus.PENABLE = 1'b1;
    sawReady = 0;
    for (int c = 0; c < 20 && !sawReady; c++) begin
      @(negedge pclk);
      if (bus.PREADY) sawReady = 1;
      else begin
        @(posedge pclk); #1;
      end
    end
    checkOutput("rst_completion_seen", 32'(sawReady), 32'd1);
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0;
    driveIdle();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge pclk);
    checkOutput("rst_pready", 32'(bus.PREADY), 32'd0);
    checkOutput("rst_prdata", bus.PRDATA, 32'h0);
    @(posedge pclk); #1;
    applyStimulus(1'b0, 5'd7, 32'h0, 4'hF);
    applyStimulus(1'b0, 5'b10010, 32'h0, 4'hF);
    applyStimulus(1'b0, 5'd0, 32'h0, 4'hF);

    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
